// File: rtl/snoop_step_sequencer.sv
// Sequencer for the MESI snooping caches: takes one memory instruction, broadcasts it,
// and walks the shared step code until a read hit, the final step, or a step timeout.

module snoop_step_lane (
  input  logic        sel,
  input  logic        drive,
  input  logic        write,
  input  logic        instrDone,
  input  logic [30:0] res,
  output logic        readBit,
  output logic        writeBit,
  output logic        hitBit,
  output logic [30:0] resSel
);
  assign readBit  = drive & sel & ~write;
  assign writeBit = drive & sel & write;
  assign hitBit   = sel & instrDone;
  assign resSel   = sel ? res : '0;
endmodule

module snoop_step_sequencer #(
  parameter int NUM_PROC = 3,
  parameter int TIMEOUT  = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instrValid,
  output logic                  instrReady,
  input  logic [1:0]            instrProc,
  input  logic                  instrWrite,
  input  logic [11:0]           instrTag,
  input  logic [15:0]           instrData,
  output logic [2:0]            step,
  output logic                  cacheReset,
  output logic [NUM_PROC-1:0]   readIn,
  output logic [NUM_PROC-1:0]   writeIn,
  output logic [11:0]           tagIn,
  output logic [15:0]           dataIn,
  output logic [11:0]           tagB,
  input  logic [NUM_PROC*5-1:0] stepDone,
  input  logic [NUM_PROC-1:0]   instrDoneIn,
  input  logic [NUM_PROC*31-1:0] resultIn,
  output logic                  done,
  output logic [30:0]           result,
  output logic                  timeout
);
  typedef enum logic [3:0] {IDLE, CLEAR, S1, S2, S3, S4, S5, S6, FIN} state_t;

  localparam logic [2:0] NPROC = 3'(NUM_PROC);
  localparam logic [7:0] TMO   = 8'(TIMEOUT);

  state_t                     state, nxt;
  logic [1:0]                 procQ;
  logic                       writeQ;
  logic [11:0]                tagQ;
  logic [15:0]                dataQ;
  logic [7:0]                 cnt, cntNxt;
  logic                       timeoutQ, illegalQ, toSet;
  logic [30:0]                resultQ, resMux;
  logic                       drive, adv, hit, accept, illegal;
  logic [4:0]                 allDone;
  logic [2:0]                 stepNum;
  logic [NUM_PROC-1:0]        hitV;
  logic [NUM_PROC-1:0][30:0]  resV;

  assign accept  = instrValid & (state == IDLE);
  assign illegal = {1'b0, instrProc} >= NPROC;

  for (genvar p = 0; p < NUM_PROC; p++) begin : g_lane
    snoop_step_lane u_lane (
      .sel      (procQ == 2'(p)),
      .drive    (drive),
      .write    (writeQ),
      .instrDone(instrDoneIn[p]),
      .res      (resultIn[31*p +: 31]),
      .readBit  (readIn[p]),
      .writeBit (writeIn[p]),
      .hitBit   (hitV[p]),
      .resSel   (resV[p])
    );
  end

  // allDone[k-1]: every cache has raised step(k)Done
  always_comb begin
    allDone = '1;
    resMux  = '0;
    for (int p = 0; p < NUM_PROC; p++) begin
      allDone &= stepDone[5*p +: 5];
      resMux  |= resV[p];
    end
  end

  assign hit = |hitV;

  always_comb begin
    nxt        = state;
    cntNxt     = '0;
    toSet      = 1'b0;
    adv        = 1'b0;
    stepNum    = 3'd0;
    cacheReset = 1'b0;
    drive      = 1'b0;
    case (state)
      IDLE:    if (accept && !illegal) nxt = CLEAR;
      CLEAR: begin
        cacheReset = 1'b1;
        drive      = 1'b1;
        nxt        = S1;
      end
      S1:      begin stepNum = 3'd1; adv = allDone[0]; end
      S2:      begin stepNum = 3'd2; adv = allDone[1]; end
      S3:      begin stepNum = 3'd3; adv = allDone[2]; end
      S4:      begin stepNum = 3'd4; adv = allDone[3]; end
      S5:      begin stepNum = 3'd5; adv = allDone[4]; end
      S6:      begin stepNum = 3'd6; adv = hit;        end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // Advance is checked before the timeout so a last-cycle advance still wins.
    if (stepNum != 3'd0) begin
      drive = 1'b1;
      if (adv) begin
        case (state)
          S1:      nxt = S2;
          S2:      nxt = hit ? FIN : S3;
          S3:      nxt = S4;
          S4:      nxt = S5;
          S5:      nxt = S6;
          default: nxt = FIN;
        endcase
      end else if (cnt + 8'd1 == TMO) begin
        nxt   = FIN;
        toSet = 1'b1;
      end else begin
        cntNxt = cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      procQ    <= '0;
      writeQ   <= 1'b0;
      tagQ     <= '0;
      dataQ    <= '0;
      cnt      <= '0;
      timeoutQ <= 1'b0;
      illegalQ <= 1'b0;
      resultQ  <= '0;
    end else begin
      state    <= nxt;
      cnt      <= cntNxt;
      illegalQ <= 1'b0;
      if (accept) begin
        timeoutQ <= illegal;
        illegalQ <= illegal;
        if (illegal) begin
          resultQ <= '0;
        end else begin
          procQ  <= instrProc;
          writeQ <= instrWrite;
          tagQ   <= instrTag;
          dataQ  <= instrData;
        end
      end else if (toSet) begin
        timeoutQ <= 1'b1;
      end
      if (state == FIN) resultQ <= resMux;
    end
  end

  assign step       = stepNum;
  assign instrReady = (state == IDLE);
  assign done       = (state == FIN) | illegalQ;
  assign result     = (state == FIN) ? resMux : resultQ;
  assign timeout    = timeoutQ;
  assign tagIn      = tagQ;
  assign tagB       = tagQ;
  assign dataIn     = dataQ;
endmodule

// File: tb/tb_snoop_step_sequencer.sv
// Bench for snoop_step_sequencer: emulated caches with random per-step latencies, stalls
// and noise, checked cycle by cycle against a step-trace model of each instruction.

module tb_snoop_step_sequencer;
  localparam int NP = 3;
  localparam int TO = 15;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                instrValid, instrReady, instrWrite, cacheReset, done, timeout;
  logic [1:0]          instrProc;
  logic [11:0]         instrTag, tagIn, tagB;
  logic [15:0]         instrData, dataIn;
  logic [2:0]          step;
  logic [NP-1:0]       readIn, writeIn, instrDoneIn;
  logic [NP*5-1:0]     stepDone;
  logic [NP*31-1:0]    resultIn;
  logic [30:0]         result;

  int nCmp = 0;
  int nErr = 0;

  always #5 clock = ~clock;

  snoop_step_sequencer #(.NUM_PROC(NP), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .instrValid(instrValid), .instrReady(instrReady),
    .instrProc(instrProc), .instrWrite(instrWrite), .instrTag(instrTag), .instrData(instrData),
    .step(step), .cacheReset(cacheReset), .readIn(readIn), .writeIn(writeIn), .tagIn(tagIn),
    .dataIn(dataIn), .tagB(tagB), .stepDone(stepDone), .instrDoneIn(instrDoneIn),
    .resultIn(resultIn), .done(done), .result(result), .timeout(timeout)
  );

  typedef struct packed {
    logic [1:0]      proc;
    logic            wr;
    logic            hit;
    logic [6:1][4:0] d;      // cycles a step is shown before its done flags rise
    logic [2:0]      stall;  // step that never completes (0 = none)
    logic [1:0]      staller;
    logic [11:0]     tag;
    logic [15:0]     data;
  } ins_t;

  typedef struct packed {
    logic [2:0] st;
    logic       clr;
    logic       fin;
  } cyc_t;

  cyc_t          tr[$];
  logic [NP*5-1:0] sd;
  logic [NP-1:0]   idn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input ins_t x, input bit v);
    instrValid = v;
    instrProc  = x.proc;
    instrWrite = x.wr;
    instrTag   = x.tag;
    instrData  = x.data;
  endtask

  function automatic ins_t mk(input int proc, input bit wr, input bit hit, input int dv,
                              input int stall, input int staller, input int tag, input int data);
    ins_t x;
    x.proc    = 2'(proc);
    x.wr      = wr;
    x.hit     = hit;
    for (int k = 1; k <= 6; k++) x.d[k] = 5'(dv);
    x.stall   = 3'(stall);
    x.staller = 2'(staller);
    x.tag     = 12'(tag);
    x.data    = 16'(data);
    return x;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t x;
    int r;
    x.proc = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, NP-1));
    x.wr   = 1'($urandom_range(0, 1));
    x.hit  = !x.wr && ($urandom_range(0, 1) == 1);
    for (int k = 1; k <= 6; k++) begin
      r = int'($urandom_range(0, 19));
      x.d[k] = (r < 16) ? 5'(r % 4) : ((r < 18) ? 5'd14 : 5'd15);
    end
    x.stall   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
    x.staller = 2'($urandom_range(0, NP-1));
    x.tag     = 12'($urandom);
    x.data    = 16'($urandom);
    return x;
  endfunction

  // Expected per-cycle trace from accept: CLEAR, each step for as long as its flags
  // take (capped at TO cycles, which means timeout), then FIN.
  task automatic build(input ins_t x, output logic expTo);
    int cyc;
    bit tmo;
    tr.delete();
    tr.push_back('{3'd0, 1'b1, 1'b0});
    expTo = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tmo = (int'(x.stall) == k) || (int'(x.d[k]) >= TO);
      cyc = tmo ? TO : int'(x.d[k]) + 1;
      repeat (cyc) tr.push_back('{3'(k), 1'b0, 1'b0});
      if (tmo) begin
        expTo = 1'b1;
        break;
      end
      if (k == 2 && x.hit) break;
    end
    tr.push_back('{3'd0, 1'b0, 1'b1});
  endtask

  // Runs one instruction whose fields are already driven with instrValid = 1.
  task automatic run_instr(input ins_t cur, input bit bp, input ins_t nx, input bit nvalid);
    logic          expTo;
    logic [30:0]   expRes;
    logic [NP-1:0] oh, rn;
    logic [NP*5-1:0] nz;
    logic [95:0]   r96;
    int            j, k, dk, xl, pi;
    bit            stl;
    @(posedge clock);
    if (int'(cur.proc) >= NP) begin
      #1 set_instr(nx, nvalid);
      #1;
      chk("ill_done", 32'(done), 32'd1);
      chk("ill_tmo", 32'(timeout), 32'd1);
      chk("ill_res", 32'(result), 32'd0);
      chk("ill_step", 32'(step), 32'd0);
      chk("ill_rdy", 32'(instrReady), 32'd1);
      return;
    end
    pi = int'(cur.proc);
    oh = '0;
    oh[pi] = 1'b1;
    build(cur, expTo);
    expRes = '0;
    for (int i = 0; i < tr.size(); i++) begin
      if (i > 0) @(posedge clock);
      #1;
      set_instr(nx, bp);
      j = 0;
      while (i - j - 1 >= 0 && tr[i-j-1] == tr[i]) j++;
      nz = '0;
      if (tr[i].clr) begin
        sd  = '0;
        idn = '0;
      end else if (!tr[i].fin) begin
        k   = int'(tr[i].st);
        dk  = int'(cur.d[k]);
        stl = (int'(cur.stall) == k);
        if (k <= 5) begin
          xl = stl ? int'(cur.staller) : int'($urandom_range(0, NP-1));
          for (int p = 0; p < NP; p++) begin
            if (j >= dk && !(stl && p == xl)) sd[5*p+k-1] = 1'b1;
            if (p != xl && $urandom_range(0, 1) == 1) nz[5*p+k-1] = 1'b1;
          end
        end
        if (k == 2 && cur.hit && j >= dk) idn[pi] = 1'b1;
        if (k == 6 && !stl && j >= dk) idn[pi] = 1'b1;
      end
      rn = NP'($urandom);
      stepDone    = sd | nz;
      instrDoneIn = idn | (rn & ~oh);
      r96 = {$urandom, $urandom, $urandom};
      resultIn = r96[NP*31-1:0];
      #1;
      chk("step", 32'(step), 32'(tr[i].st));
      chk("cache_reset", 32'(cacheReset), 32'(tr[i].clr));
      chk("done", 32'(done), 32'(tr[i].fin));
      chk("read_in", 32'(readIn), (tr[i].fin || cur.wr) ? 32'd0 : 32'(oh));
      chk("write_in", 32'(writeIn), (tr[i].fin || !cur.wr) ? 32'd0 : 32'(oh));
      chk("busy_rdy", 32'(instrReady), 32'd0);
      chk("timeout", 32'(timeout), tr[i].fin ? 32'(expTo) : 32'd0);
      chk("tag_in", 32'(tagIn), 32'(cur.tag));
      chk("tag_b", 32'(tagB), 32'(cur.tag));
      chk("data_in", 32'(dataIn), 32'(cur.data));
      if (tr[i].fin) begin
        expRes = resultIn[31*pi +: 31];
        chk("fin_result", 32'(result), 32'(expRes));
      end
    end
    @(posedge clock);
    #1 set_instr(nx, nvalid);
    #1;
    chk("idle_rdy", 32'(instrReady), 32'd1);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_step", 32'(step), 32'd0);
    chk("idle_result", 32'(result), 32'(expRes));
    chk("idle_tmo", 32'(timeout), 32'(expTo));
  endtask

  initial begin
    ins_t q[$];
    bit   bpq[$];
    ins_t w, nx;
    int   wcnt;

    instrValid = 1'b0; instrProc = '0; instrWrite = 1'b0; instrTag = '0; instrData = '0;
    stepDone = '0; instrDoneIn = '0; resultIn = '0; sd = '0; idn = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_rdy", 32'(instrReady), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tmo", 32'(timeout), 32'd0);
    chk("rst_crst", 32'(cacheReset), 32'd0);
    chk("rst_rw", 32'({readIn, writeIn}), 32'd0);
    chk("rst_tag", 32'({tagIn, tagB}), 32'd0);
    chk("rst_data", 32'(dataIn), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    #10 reset = 1'b1;

    q.push_back(mk(0, 1'b0, 1'b1, 0, 0, 0, 'h118, 'h0000)); bpq.push_back(1'b0);
    q.push_back(mk(1, 1'b1, 1'b0, 0, 0, 0, 'h110, 'h00AA)); bpq.push_back(1'b0);
    q.push_back(mk(2, 1'b1, 1'b0, 0, 3, 2, 'h3C5, 'h1234)); bpq.push_back(1'b1);
    q.push_back(mk(0, 1'b0, 1'b0, 1, 0, 0, 'h0F0, 'h0000)); bpq.push_back(1'b0);
    q.push_back(mk(3, 1'b0, 1'b0, 0, 0, 0, 'h777, 'hBEEF)); bpq.push_back(1'b0);
    w = mk(2, 1'b1, 1'b0, 0, 0, 0, 'hABC, 'h5A5A);
    w.d[4] = 5'd14;
    q.push_back(w); bpq.push_back(1'b1);
    w = mk(1, 1'b0, 1'b0, 2, 0, 0, 'h00F, 'h0000);
    w.d[5] = 5'd15;
    q.push_back(w); bpq.push_back(1'b0);
    w = mk(2, 1'b0, 1'b1, 1, 0, 0, 'hFFF, 'h0000);
    w.d[2] = 5'd3;
    q.push_back(w); bpq.push_back(1'b0);
    for (int n = 0; n < 40; n++) begin
      q.push_back(rnd_ins());
      bpq.push_back(1'($urandom_range(0, 1)));
    end

    set_instr(q[0], 1'b1);
    for (int n = 0; n < q.size(); n++) begin
      nx = (n + 1 < q.size()) ? q[n+1] : q[0];
      run_instr(q[n], bpq[n], nx, n + 1 < q.size());
    end

    // Asynchronous reset in S4: caches ack every step at once.
    w = mk(1, 1'b1, 1'b0, 0, 0, 0, 'h246, 'h1357);
    stepDone = '1;
    instrDoneIn = '0;
    set_instr(w, 1'b1);
    @(posedge clock);
    #1 set_instr(w, 1'b0);
    wcnt = 0;
    while (step !== 3'd4 && wcnt < 20) begin
      @(posedge clock);
      #1 wcnt++;
    end
    chk("reach_s4", 32'(step), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("arst_step", 32'(step), 32'd0);
    chk("arst_rdy", 32'(instrReady), 32'd1);
    chk("arst_rw", 32'({readIn, writeIn}), 32'd0);
    chk("arst_tag", 32'({tagIn, tagB}), 32'd0);
    chk("arst_data", 32'(dataIn), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_tmo", 32'(timeout), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_crst", 32'(cacheReset), 32'd0);
    #10 reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
